cp0_unit: RTL

Coprocessor-0 block for the five-stage MIPS pipeline. It sits beside the memory stage and consumes that stage's exception metadata: exception code, branch-delay flag and macroscopic PC. It arbitrates exceptions against external interrupts and drives `req`, the flush and redirect signal that every pipeline register and the PC use to jump to the 0x0000_4180 handler. It also implements `mtc0`/`mfc0` access to SR, Cause, EPC and PRId, and the `eret` return.

---
 rtl/cp0_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cp0_unit.sv
// Coprocessor 0: exception/interrupt arbitration, SR/Cause/EPC/PRId, eret.
// Optional BadVAddr (reg 8) when CP0_BADVADDR_EN is defined.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h0BAD_2021
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  ex_code_in,
  input  logic [31:0] bad_vaddr_in,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic        req,
  output logic [31:0] epc_out
);

  typedef enum logic {
    NORMAL  = 1'b0,
    HANDLER = 1'b1
  } state_t;

  state_t state, state_nx;

  logic [5:0]  im;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        exl;
  logic        int_req;
  logic        exc_req;
  logic        sr_we;
  logic        epc_we;
  logic [31:0] epc_new;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  assign exl     = (state == HANDLER);
  assign int_req = (|(hw_int & im)) & ie & ~exl;
  assign exc_req = (ex_code_in != 5'd0) & ~exl;
  // Held low during reset so the pipeline never redirects mid-reset.
  assign req     = ~reset & (int_req | exc_req);

  assign sr_we   = we && (cp0_addr == 5'd12);
  assign epc_we  = we && (cp0_addr == 5'd14);
  assign epc_new = (bd_in ? vpc - 32'd4 : vpc) & ~32'd3;

  always_comb begin
    state_nx = state;
    if (req) begin
      state_nx = HANDLER;
    end else if (sr_we) begin
      state_nx = (eret || !cp0_wdata[1]) ? NORMAL : HANDLER;
    end else if (eret) begin
      state_nx = NORMAL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= NORMAL;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im       <= '0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= hw_int;
      if (req) begin
        bd       <= bd_in;
        exc_code <= int_req ? 5'd0 : ex_code_in;
        epc      <= epc_new;
      end else begin
        if (sr_we) begin
          im <= cp0_wdata[15:10];
          ie <= cp0_wdata[0];
        end
        if (epc_we) epc <= cp0_wdata & ~32'd3;
      end
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] bad_vaddr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_vaddr <= '0;
    end else if (req && !int_req &&
                 (ex_code_in == 5'd4 || ex_code_in == 5'd5)) begin
      bad_vaddr <= bad_vaddr_in;
    end
  end
`else
  logic [31:0] bad_vaddr;
  logic        unused_bad_vaddr;

  assign bad_vaddr        = '0;
  assign unused_bad_vaddr = ^bad_vaddr_in;
`endif

  assign sr_val    = {16'b0, im, 8'b0, exl, ie};
  assign cause_val = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      5'd8:    cp0_rdata = bad_vaddr;
      5'd12:   cp0_rdata = sr_val;
      5'd13:   cp0_rdata = cause_val;
      5'd14:   cp0_rdata = epc;
      5'd15:   cp0_rdata = PRID;
      default: cp0_rdata = '0;
    endcase
  end

  assign epc_out = epc_we ? (cp0_wdata & ~32'd3) : epc;

endmodule
